// File: rtl/fl_pkg.sv
// Shared constants, flag layout and operand classification for the pipelined FP units.
package fl_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;
  localparam int unsigned W         = 1 + EXP_W_DEF + MAN_W_DEF;
  localparam int unsigned BIAS      = 2 ** (EXP_W_DEF - 1) - 1;

  localparam int unsigned FLG_NV = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } fl_class_t;

  // Width-agnostic: the caller reduces the exponent/fraction fields. Denormals count as zero.
  function automatic fl_class_t classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero, input logic frac_msb);
    fl_class_t c;
    c.zero = exp_zero;
    c.inf  = exp_ones & frac_zero;
    c.nan  = exp_ones & ~frac_zero;
    c.snan = exp_ones & ~frac_zero & ~frac_msb;
    return c;
  endfunction

endpackage

// File: rtl/fl_mul_round.sv
// Combinational normalise, round and pack of a raw significand product with biased exponent.
module fl_mul_round import fl_pkg::*; #(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [2*MAN_W+1:0]       prod_i,
  input  logic                     rnd_i,
  output logic [EXP_W+MAN_W:0]     res_o,
  output logic [3:0]               flags_o
);

  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * SW;
  localparam int unsigned XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_MAX = XW'(2 ** EXP_W - 1);

  logic [PW-1:0]          norm;
  logic signed [XW-1:0]   exp_n, exp_f;
  logic [SW-1:0]          mant;
  logic                   g, r, s, inc, nx;
  logic [SW:0]            mant_r;
  logic [MAN_W-1:0]       frac;

  always_comb begin
    norm   = prod_i[PW-1] ? prod_i : (prod_i << 1);
    exp_n  = exp_i + $signed({{(XW-1){1'b0}}, prod_i[PW-1]});
    mant   = norm[PW-1 -: SW];
    g      = norm[MAN_W];
    r      = norm[MAN_W-1];
    s      = |norm[MAN_W-2:0];
    nx     = g | r | s;
    inc    = (rnd_i == RND_RNE) & g & (r | s | mant[0]);
    mant_r = {1'b0, mant} + (SW+1)'(inc);
    // Rounding carry-out leaves 10..0; renormalise by one place.
    exp_f  = exp_n + $signed({{(XW-1){1'b0}}, mant_r[SW]});
    frac   = mant_r[SW] ? mant_r[SW-1:1] : mant_r[SW-2:0];

    flags_o = '0;
    if (exp_f <= 0) begin
      res_o           = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_UF] = 1'b1;
      flags_o[FLG_NX] = 1'b1;
    end else if (exp_f >= EXP_MAX) begin
      flags_o[FLG_OF] = 1'b1;
      flags_o[FLG_NX] = 1'b1;
      if (rnd_i == RND_RTZ) begin
        res_o = {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end else begin
        res_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end else begin
      res_o           = {sign_i, exp_f[EXP_W-1:0], frac};
      flags_o[FLG_NX] = nx;
    end
  end

endmodule

// File: rtl/fl_mul_pipe.sv
// Three-stage floating-point multiplier with global-stall valid/ready flow control.
module fl_mul_pipe import fl_pkg::*; #(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in0,
  input  logic [EXP_W+MAN_W:0]   in1,
  input  logic                   rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic [3:0]             flags
);

  localparam int unsigned WL = 1 + EXP_W + MAN_W;
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * SW;
  localparam int unsigned XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS_X = XW'(2 ** (EXP_W - 1) - 1);
  localparam logic [WL-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic                  advance;
  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb;
  fl_class_t             ca, cb;
  logic                  sign_d, spec_d;
  logic [WL-1:0]         sres_d;
  logic [3:0]            sflg_d;
  logic signed [XW-1:0]  exp_d;

  logic                  v1_q, sign1_q, spec1_q, rnd1_q;
  logic signed [XW-1:0]  exp1_q;
  logic [SW-1:0]         ma1_q, mb1_q;
  logic [WL-1:0]         sres1_q;
  logic [3:0]            sflg1_q;

  logic                  v2_q, sign2_q, spec2_q, rnd2_q;
  logic signed [XW-1:0]  exp2_q;
  logic [PW-1:0]         prod2_q;
  logic [WL-1:0]         sres2_q;
  logic [3:0]            sflg2_q;

  logic [WL-1:0]         rnd_res;
  logic [3:0]            rnd_flg;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign ea = in0[WL-2 -: EXP_W];
  assign eb = in1[WL-2 -: EXP_W];
  assign fa = in0[MAN_W-1:0];
  assign fb = in1[MAN_W-1:0];
  assign ca = classify(ea == '0, &ea, fa == '0, fa[MAN_W-1]);
  assign cb = classify(eb == '0, &eb, fb == '0, fb[MAN_W-1]);

  always_comb begin
    sign_d = in0[WL-1] ^ in1[WL-1];
    exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
    spec_d = 1'b1;
    sres_d = '0;
    sflg_d = '0;
    // NaN beats inf*0 beats inf beats zero; only the normal path reaches S3 rounding.
    if (ca.nan | cb.nan) begin
      sres_d         = QNAN;
      sflg_d[FLG_NV] = ca.snan | cb.snan;
    end else if ((ca.inf & cb.zero) | (ca.zero & cb.inf)) begin
      sres_d         = QNAN;
      sflg_d[FLG_NV] = 1'b1;
    end else if (ca.inf | cb.inf) begin
      sres_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca.zero | cb.zero) begin
      sres_d = {sign_d, {(WL-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  fl_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign_i  (sign2_q),
    .exp_i   (exp2_q),
    .prod_i  (prod2_q),
    .rnd_i   (rnd2_q),
    .res_o   (rnd_res),
    .flags_o (rnd_flg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
      flags     <= '0;
    end else if (advance) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      if (v2_q) begin
        product <= spec2_q ? sres2_q : rnd_res;
        flags   <= spec2_q ? sflg2_q : rnd_flg;
      end
    end
  end

  // Datapath registers carry no reset; their stage valids qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      sign1_q <= sign_d;
      spec1_q <= spec_d;
      rnd1_q  <= rnd_mode;
      exp1_q  <= exp_d;
      ma1_q   <= {1'b1, fa};
      mb1_q   <= {1'b1, fb};
      sres1_q <= sres_d;
      sflg1_q <= sflg_d;

      sign2_q <= sign1_q;
      spec2_q <= spec1_q;
      rnd2_q  <= rnd1_q;
      exp2_q  <= exp1_q;
      prod2_q <= ma1_q * mb1_q;
      sres2_q <= sres1_q;
      sflg2_q <= sflg1_q;
    end
  end

endmodule
